// File: rtl/fma16_arb.sv
// Round-robin issue controller for the shared fma16 datapath: execute register E
// feeds the datapath, writeback register W returns result/flags/tag to the issuer.
// Optional performance counters are built when FMA16_ARB_PERF_EN is defined.
module fma16_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [2:0]       req_op_0,
  input  logic [15:0]      req_x_0,
  input  logic [15:0]      req_y_0,
  input  logic [15:0]      req_z_0,
  input  logic [1:0]       req_rm_0,
  input  logic [TAG_W-1:0] req_tag_0,

  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [2:0]       req_op_1,
  input  logic [15:0]      req_x_1,
  input  logic [15:0]      req_y_1,
  input  logic [15:0]      req_z_1,
  input  logic [1:0]       req_rm_1,
  input  logic [TAG_W-1:0] req_tag_1,

  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [15:0]      rsp_result_0,
  output logic [3:0]       rsp_flags_0,
  output logic [TAG_W-1:0] rsp_tag_0,

  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [15:0]      rsp_result_1,
  output logic [3:0]       rsp_flags_1,
  output logic [TAG_W-1:0] rsp_tag_1,

  output logic [15:0]      fma_x,
  output logic [15:0]      fma_y,
  output logic [15:0]      fma_z,
  output logic             fma_mul,
  output logic             fma_add,
  output logic             fma_negr,
  output logic             fma_negz,
  output logic [1:0]       fma_roundmode,
  input  logic [15:0]      fma_result,
  input  logic [3:0]       fma_flags,

  output logic             idle,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
);

  // Handshake: a request transfers on a rising edge where valid & ready are both
  // high; ready never looks at the requester's own valid. A response transfers
  // on a rising edge where rsp_valid_r & rsp_ready_r are both high.

  // Pipeline occupancy, encoded as {e_valid, w_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_DONE  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  // Returns {reserved, mul, add, negr, negz}.
  function automatic logic [4:0] decode_op(input logic [2:0] op);
    logic [4:0] d;
    case (op)
      3'd0:    d = 5'b0_0100;
      3'd1:    d = 5'b0_0101;
      3'd2:    d = 5'b0_1000;
      3'd3:    d = 5'b0_1100;
      3'd4:    d = 5'b0_1101;
      3'd5:    d = 5'b0_1110;
      3'd6:    d = 5'b0_1111;
      default: d = 5'b1_0000;
    endcase
    return d;
  endfunction

  logic             e_valid_q, e_valid_d;
  logic             e_src_q, e_src_d;
  logic [TAG_W-1:0] e_tag_q, e_tag_d;
  logic [15:0]      e_x_q, e_x_d;
  logic [15:0]      e_y_q, e_y_d;
  logic [15:0]      e_z_q, e_z_d;
  logic [3:0]       e_ctrl_q, e_ctrl_d;
  logic             e_rsvd_q, e_rsvd_d;
  logic [1:0]       e_rm_q, e_rm_d;

  logic             w_valid_q, w_valid_d;
  logic             w_src_q, w_src_d;
  logic [TAG_W-1:0] w_tag_q, w_tag_d;
  logic [15:0]      w_result_q, w_result_d;
  logic [3:0]       w_flags_q, w_flags_d;

  logic             prio_q, prio_d;

  state_e           state;
  logic             w_consume;
  logic             w_free;
  logic             e_adv;
  logic             accept;
  logic             grant_0;
  logic             grant_1;
  logic             acc;
  logic             acc_src;
  logic [2:0]       sel_op;
  logic [4:0]       sel_dec;

  assign state = state_e'({e_valid_q, w_valid_q});

  always_comb begin
    w_consume   = w_src_q ? rsp_ready_1 : rsp_ready_0;
    w_free      = !w_valid_q || w_consume;
    e_adv       = e_valid_q && w_free;
    accept      = !e_valid_q || w_free;
    req_ready_0 = accept && !(req_valid_1 && prio_q == 1'b1);
    req_ready_1 = accept && !(req_valid_0 && prio_q == 1'b0);
    grant_0     = req_valid_0 && req_ready_0;
    grant_1     = req_valid_1 && req_ready_1;
    acc         = grant_0 || grant_1;
    acc_src     = !grant_0;
    sel_op      = acc_src ? req_op_1 : req_op_0;
    sel_dec     = decode_op(sel_op);
  end

  always_comb begin
    e_valid_d  = e_valid_q;
    e_src_d    = e_src_q;
    e_tag_d    = e_tag_q;
    e_x_d      = e_x_q;
    e_y_d      = e_y_q;
    e_z_d      = e_z_q;
    e_ctrl_d   = e_ctrl_q;
    e_rsvd_d   = e_rsvd_q;
    e_rm_d     = e_rm_q;
    w_valid_d  = w_valid_q;
    w_src_d    = w_src_q;
    w_tag_d    = w_tag_q;
    w_result_d = w_result_q;
    w_flags_d  = w_flags_q;
    prio_d     = prio_q;

    if (acc) begin
      e_valid_d = 1'b1;
      e_src_d   = acc_src;
      e_tag_d   = acc_src ? req_tag_1 : req_tag_0;
      e_x_d     = acc_src ? req_x_1 : req_x_0;
      e_y_d     = acc_src ? req_y_1 : req_y_0;
      e_z_d     = acc_src ? req_z_1 : req_z_0;
      e_rm_d    = acc_src ? req_rm_1 : req_rm_0;
      e_ctrl_d  = sel_dec[3:0];
      e_rsvd_d  = sel_dec[4];
      prio_d    = !acc_src;
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end

    // The reserved opcode returns a canonical quiet NaN flagged invalid.
    if (e_adv) begin
      w_valid_d  = 1'b1;
      w_src_d    = e_src_q;
      w_tag_d    = e_tag_q;
      w_result_d = e_rsvd_q ? 16'h7E00 : fma_result;
      w_flags_d  = e_rsvd_q ? 4'b1000 : fma_flags;
    end else if (w_valid_q && w_consume) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q  <= 1'b0;
      e_src_q    <= 1'b0;
      e_tag_q    <= '0;
      e_x_q      <= '0;
      e_y_q      <= '0;
      e_z_q      <= '0;
      e_ctrl_q   <= '0;
      e_rsvd_q   <= 1'b0;
      e_rm_q     <= '0;
      w_valid_q  <= 1'b0;
      w_src_q    <= 1'b0;
      w_tag_q    <= '0;
      w_result_q <= '0;
      w_flags_q  <= '0;
      prio_q     <= 1'b0;
    end else begin
      e_valid_q  <= e_valid_d;
      e_src_q    <= e_src_d;
      e_tag_q    <= e_tag_d;
      e_x_q      <= e_x_d;
      e_y_q      <= e_y_d;
      e_z_q      <= e_z_d;
      e_ctrl_q   <= e_ctrl_d;
      e_rsvd_q   <= e_rsvd_d;
      e_rm_q     <= e_rm_d;
      w_valid_q  <= w_valid_d;
      w_src_q    <= w_src_d;
      w_tag_q    <= w_tag_d;
      w_result_q <= w_result_d;
      w_flags_q  <= w_flags_d;
      prio_q     <= prio_d;
    end
  end

  // Datapath inputs are forced quiet whenever E holds nothing.
  always_comb begin
    fma_x         = e_valid_q ? e_x_q : 16'h0;
    fma_y         = e_valid_q ? e_y_q : 16'h0;
    fma_z         = e_valid_q ? e_z_q : 16'h0;
    fma_mul       = e_valid_q && e_ctrl_q[3];
    fma_add       = e_valid_q && e_ctrl_q[2];
    fma_negr      = e_valid_q && e_ctrl_q[1];
    fma_negz      = e_valid_q && e_ctrl_q[0];
    fma_roundmode = e_valid_q ? e_rm_q : 2'b00;
  end

  always_comb begin
    rsp_valid_0  = w_valid_q && !w_src_q;
    rsp_valid_1  = w_valid_q && w_src_q;
    rsp_result_0 = w_result_q;
    rsp_result_1 = w_result_q;
    rsp_flags_0  = w_flags_q;
    rsp_flags_1  = w_flags_q;
    rsp_tag_0    = w_tag_q;
    rsp_tag_1    = w_tag_q;
    idle         = (state == ST_EMPTY);
  end

`ifdef FMA16_ARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (acc) issue_cnt_d = issue_cnt_q + 32'd1;
    if (w_valid_q && !w_consume) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_issue_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fma16_arb.sv
// Directed bench for fma16_arb; a stand-in fma16 model drives fma_result/fma_flags.
module tb_fma16_arb;
  localparam int TAG_W = 4;
  localparam int QW    = 1 + TAG_W + 16 + 4;

  logic             clk;
  logic             reset;
  logic             req_valid_0, req_valid_1;
  logic             req_ready_0, req_ready_1;
  logic [2:0]       req_op_0, req_op_1;
  logic [15:0]      req_x_0, req_y_0, req_z_0, req_x_1, req_y_1, req_z_1;
  logic [1:0]       req_rm_0, req_rm_1;
  logic [TAG_W-1:0] req_tag_0, req_tag_1;
  logic             rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [15:0]      rsp_result_0, rsp_result_1;
  logic [3:0]       rsp_flags_0, rsp_flags_1;
  logic [TAG_W-1:0] rsp_tag_0, rsp_tag_1;
  logic [15:0]      fma_x, fma_y, fma_z, fma_result;
  logic             fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]       fma_roundmode;
  logic [3:0]       fma_flags;
  logic             idle;
  logic [31:0]      perf_issue_cnt, perf_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q[$];

  fma16_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
    .req_x_0(req_x_0), .req_y_0(req_y_0), .req_z_0(req_z_0), .req_rm_0(req_rm_0), .req_tag_0(req_tag_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
    .req_x_1(req_x_1), .req_y_1(req_y_1), .req_z_1(req_z_1), .req_rm_1(req_rm_1), .req_tag_1(req_tag_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_result_0(rsp_result_0),
    .rsp_flags_0(rsp_flags_0), .rsp_tag_0(rsp_tag_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_result_1(rsp_result_1),
    .rsp_flags_1(rsp_flags_1), .rsp_tag_1(rsp_tag_1),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode), .fma_result(fma_result), .fma_flags(fma_flags),
    .idle(idle), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in datapath: two real binary16 cases, otherwise an easily predicted mix.
  function automatic logic [19:0] dp_model(input logic [15:0] x, y, z, input logic [3:0] c,
                                           input logic [1:0] rm);
    logic [19:0] r;
    if (c == 4'b1000 && x == 16'h3C00 && y == 16'h4000)
      r = {16'h4000, 4'b0000};
    else if (c == 4'b1100 && x == 16'h4000 && y == 16'h4200 && z == 16'h3C00)
      r = {16'h4700, 4'b0000};
    else
      r = {x ^ {y[7:0], y[15:8]} ^ z ^ {12'h0, c}, x[3:0] ^ y[3:0] ^ {rm, rm}};
    return r;
  endfunction

  function automatic logic [3:0] ctrl_of(input logic [2:0] op);
    logic [3:0] c;
    case (op)
      3'd0: c = 4'b0100;
      3'd1: c = 4'b0101;
      3'd2: c = 4'b1000;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1110;
      3'd6: c = 4'b1111;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  always_comb {fma_result, fma_flags} = dp_model(fma_x, fma_y, fma_z,
    {fma_mul, fma_add, fma_negr, fma_negz}, fma_roundmode);

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid_0 = 0; req_op_0 = 0; req_x_0 = 0; req_y_0 = 0; req_z_0 = 0; req_rm_0 = 0; req_tag_0 = 0;
    req_valid_1 = 0; req_op_1 = 0; req_x_1 = 0; req_y_1 = 0; req_z_1 = 0; req_rm_1 = 0; req_tag_1 = 0;
    rsp_ready_0 = 1; rsp_ready_1 = 1;
  endtask

  task automatic drive_0(input logic [2:0] op, input logic [15:0] x, y, z, input logic [1:0] rm,
                         input logic [TAG_W-1:0] tag);
    req_valid_0 = 1; req_op_0 = op; req_x_0 = x; req_y_0 = y; req_z_0 = z; req_rm_0 = rm; req_tag_0 = tag;
  endtask

  task automatic drive_1(input logic [2:0] op, input logic [15:0] x, y, z, input logic [1:0] rm,
                         input logic [TAG_W-1:0] tag);
    req_valid_1 = 1; req_op_1 = op; req_x_1 = x; req_y_1 = y; req_z_1 = z; req_rm_1 = rm; req_tag_1 = tag;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, idle} !== 5'b11001) begin
      n_err++; $display("FAIL reset_hs: got %b want 11001", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, idle});
    end
    n_cmp++;
    if ({fma_x, fma_mul, fma_add, rsp_result_0, rsp_flags_1, rsp_tag_0} !== 42'h0) begin
      n_err++; $display("FAIL reset_regs: got %h want 0", {fma_x, fma_mul, fma_add, rsp_result_0, rsp_flags_1, rsp_tag_0});
    end
    n_cmp++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'h0) begin
      n_err++; $display("FAIL reset_perf: got %h want 0", {perf_issue_cnt, perf_stall_cnt});
    end
    reset = 0;
  endtask

  task automatic test_fmul_r0();
    @(negedge clk);
    drive_0(3'd2, 16'h3C00, 16'h4000, 16'h0000, 2'd0, 4'd3);
    #1;
    n_cmp++;
    if (req_ready_0 !== 1'b1) begin n_err++; $display("FAIL fmul_ready: got %b want 1", req_ready_0); end
    @(negedge clk);
    req_valid_0 = 0;
    #1;
    n_cmp++;
    if ({fma_mul, fma_add, fma_negr, fma_negz, fma_x, fma_y, rsp_valid_0, idle} !== {4'b1000, 16'h3C00, 16'h4000, 2'b00}) begin
      n_err++; $display("FAIL fmul_exec: got %h want %h", {fma_mul, fma_add, fma_negr, fma_negz, fma_x, fma_y, rsp_valid_0, idle},
                        {4'b1000, 16'h3C00, 16'h4000, 2'b00});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid_0, rsp_valid_1, rsp_result_0, rsp_flags_0, rsp_tag_0} !== {2'b10, 16'h4000, 4'h0, 4'd3}) begin
      n_err++; $display("FAIL fmul_rsp: got %h want %h", {rsp_valid_0, rsp_valid_1, rsp_result_0, rsp_flags_0, rsp_tag_0},
                        {2'b10, 16'h4000, 4'h0, 4'd3});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({idle, rsp_valid_0} !== 2'b10) begin n_err++; $display("FAIL fmul_drain: got %b want 10", {idle, rsp_valid_0}); end
  endtask

  task automatic test_fmadd_r1();
    @(negedge clk);
    drive_1(3'd3, 16'h4000, 16'h4200, 16'h3C00, 2'd0, 4'd5);
    #1;
    n_cmp++;
    if (req_ready_1 !== 1'b1) begin n_err++; $display("FAIL fmadd_ready: got %b want 1", req_ready_1); end
    @(negedge clk);
    req_valid_1 = 0;
    #1;
    n_cmp++;
    if ({fma_mul, fma_add, fma_negr, fma_negz, fma_z} !== {4'b1100, 16'h3C00}) begin
      n_err++; $display("FAIL fmadd_exec: got %h want %h", {fma_mul, fma_add, fma_negr, fma_negz, fma_z}, {4'b1100, 16'h3C00});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid_0, rsp_valid_1, rsp_result_1, rsp_tag_1} !== {2'b01, 16'h4700, 4'd5}) begin
      n_err++; $display("FAIL fmadd_rsp: got %h want %h", {rsp_valid_0, rsp_valid_1, rsp_result_1, rsp_tag_1}, {2'b01, 16'h4700, 4'd5});
    end
    @(negedge clk);
  endtask

  // Both requesters always valid; prio is 0 here, so grants go r0,r1,r0,...
  task automatic test_back_to_back();
    int cnt0 = 0;
    int cnt1 = 0;
    logic [2:0] op_tab [0:3];
    logic [QW-1:0] got, want;
    logic [19:0] r;
    op_tab[0] = 3'd0; op_tab[1] = 3'd1; op_tab[2] = 3'd4; op_tab[3] = 3'd5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid_0 || rsp_valid_1) begin
        got  = {rsp_valid_1, rsp_valid_1 ? rsp_tag_1 : rsp_tag_0, rsp_valid_1 ? rsp_result_1 : rsp_result_0,
                rsp_valid_1 ? rsp_flags_1 : rsp_flags_0};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL b2b_rsp cyc %0d: got %h want %h", i, got, want); end
      end
      if (i < 6) begin
        drive_0(op_tab[cnt0 % 4], 16'h1100 + 16'(cnt0), 16'h2203, 16'h0F0F, 2'(cnt0), 4'(cnt0));
        drive_1(op_tab[(cnt1 + 2) % 4], 16'h5500 + 16'(cnt1), 16'h6607, 16'h00F0, 2'(cnt1 + 1), 4'(8 + cnt1));
      end else begin
        req_valid_0 = 0; req_valid_1 = 0;
      end
      #1;
      if (i < 6) begin
        n_cmp++;
        if ({req_ready_0, req_ready_1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL b2b_grant cyc %0d: got %b want %b", i, {req_ready_0, req_ready_1}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        if (i % 2 == 0) begin
          r = dp_model(req_x_0, req_y_0, req_z_0, ctrl_of(req_op_0), req_rm_0);
          exp_q.push_back({1'b0, req_tag_0, r});
          cnt0++;
        end else begin
          r = dp_model(req_x_1, req_y_1, req_z_1, ctrl_of(req_op_1), req_rm_1);
          exp_q.push_back({1'b1, req_tag_1, r});
          cnt1++;
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_lost: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready_0 = 0;
    drive_0(3'd2, 16'h0101, 16'h0202, 16'h0, 2'd0, 4'd1);
    @(negedge clk);
    drive_0(3'd2, 16'h0303, 16'h0404, 16'h0, 2'd0, 4'd2);
    @(negedge clk);
    drive_0(3'd2, 16'h0505, 16'h0606, 16'h0, 2'd0, 4'd3);
    // Now FULL: W holds tag 1, E holds tag 2, tag 3 waits.
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_tag_0, rsp_result_0, fma_x} !==
          {3'b001, 4'd1, 16'h0101 ^ 16'h0202 ^ 16'h0008, 16'h0303}) begin
        n_err++; $display("FAIL bp_hold cyc %0d: got %h want %h", i,
                          {req_ready_0, req_ready_1, rsp_valid_0, rsp_tag_0, rsp_result_0, fma_x},
                          {3'b001, 4'd1, 16'h0101 ^ 16'h0202 ^ 16'h0008, 16'h0303});
      end
      @(negedge clk);
    end
    rsp_ready_0 = 1;
    #1;
    n_cmp++;
    if ({req_ready_0, rsp_tag_0} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL bp_release: got %h want %h", {req_ready_0, rsp_tag_0}, {1'b1, 4'd1});
    end
    @(negedge clk);
    req_valid_0 = 0;
    #1;
    n_cmp++;
    if ({rsp_valid_0, rsp_tag_0, fma_x} !== {1'b1, 4'd2, 16'h0505}) begin
      n_err++; $display("FAIL bp_second: got %h want %h", {rsp_valid_0, rsp_tag_0, fma_x}, {1'b1, 4'd2, 16'h0505});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid_0, rsp_tag_0} !== {1'b1, 4'd3}) begin
      n_err++; $display("FAIL bp_third: got %h want %h", {rsp_valid_0, rsp_tag_0}, {1'b1, 4'd3});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({idle, rsp_valid_0, rsp_valid_1} !== 3'b100) begin
      n_err++; $display("FAIL bp_drain: got %b want 100", {idle, rsp_valid_0, rsp_valid_1});
    end
`ifdef FMA16_ARB_PERF_EN
    n_cmp++;
    if ({perf_issue_cnt, perf_stall_cnt} !== {32'd11, 32'd5}) begin
      n_err++; $display("FAIL bp_perf: got %h want %h", {perf_issue_cnt, perf_stall_cnt}, {32'd11, 32'd5});
    end
`else
    n_cmp++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'h0) begin
      n_err++; $display("FAIL bp_perf_off: got %h want 0", {perf_issue_cnt, perf_stall_cnt});
    end
`endif
  endtask

  task automatic test_reserved();
    @(negedge clk);
    drive_1(3'd7, 16'h1234, 16'h5678, 16'h9ABC, 2'd1, 4'd9);
    @(negedge clk);
    req_valid_1 = 0;
    #1;
    n_cmp++;
    if (fma_x !== 16'h1234) begin n_err++; $display("FAIL rsvd_exec: got %h want 1234", fma_x); end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid_1, rsp_result_1, rsp_flags_1, rsp_tag_1} !== {1'b1, 16'h7E00, 4'b1000, 4'd9}) begin
      n_err++; $display("FAIL rsvd_rsp: got %h want %h", {rsp_valid_1, rsp_result_1, rsp_flags_1, rsp_tag_1},
                        {1'b1, 16'h7E00, 4'b1000, 4'd9});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    rsp_ready_0 = 0;
    drive_0(3'd0, 16'h0011, 16'h0022, 16'h0, 2'd0, 4'd6);
    @(negedge clk);
    drive_0(3'd0, 16'h0033, 16'h0044, 16'h0, 2'd0, 4'd7);
    @(negedge clk);
    req_valid_0 = 0;
    #1;
    n_cmp++;
    if ({rsp_valid_0, idle, req_ready_0} !== 3'b100) begin
      n_err++; $display("FAIL flush_full: got %b want 100", {rsp_valid_0, idle, req_ready_0});
    end
    reset = 1;
    #1;
    n_cmp++;
    if ({rsp_valid_0, rsp_valid_1, idle, req_ready_0, req_ready_1, fma_x} !== {5'b00111, 16'h0}) begin
      n_err++; $display("FAIL flush_now: got %h want %h", {rsp_valid_0, rsp_valid_1, idle, req_ready_0, req_ready_1, fma_x},
                        {5'b00111, 16'h0});
    end
    @(negedge clk);
    reset = 0;
    rsp_ready_0 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({rsp_valid_0, rsp_valid_1, idle} !== 3'b001) begin
        n_err++; $display("FAIL flush_quiet cyc %0d: got %b want 001", i, {rsp_valid_0, rsp_valid_1, idle});
      end
    end
    n_cmp++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'h0) begin
      n_err++; $display("FAIL flush_perf: got %h want 0", {perf_issue_cnt, perf_stall_cnt});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_fmul_r0();
    test_fmadd_r1();
    test_back_to_back();
    test_backpressure();
    test_reserved();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
